// File: rtl/cache_pkg.sv
// Shared FSM state type, default geometry and address-field helpers for assoc_cache.
package cache_pkg;
   typedef enum logic [1:0] {IDLE, FILL, UPDATE} fill_state_t;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_SETS   = 64;
   localparam int DEF_WAYS   = 2;
   localparam int DEF_WORDS  = 8;

   localparam int DEF_OFF_W = $clog2(DEF_WORDS);
   localparam int DEF_IDX_W = $clog2(DEF_SETS);
   localparam int DEF_TAG_W = DEF_ADDR_W - 1 - DEF_OFF_W - DEF_IDX_W;

   function automatic int tag_width(int addr_w, int sets, int words);
      return addr_w - 1 - $clog2(sets) - $clog2(words);
   endfunction
endpackage

// File: rtl/cache_fill_ctrl.sv
// Line-fill controller: latches the missing block and victim, streams WORDS word reads,
// counts returns independently of issues, then signals the tag/LRU update.
module cache_fill_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WAYS   = DEF_WAYS,
   parameter int WORDS  = DEF_WORDS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       miss,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [$clog2(WAYS)-1:0]    victim,
   input  logic                       mem_rd_valid,
   output logic                       idle,
   output logic                       start,
   output logic                       stall,
   output logic                       mem_rd_req,
   output logic [ADDR_W-1:0]          mem_rd_addr,
   output logic                       fill_we,
   output logic [$clog2(WORDS)-1:0]   fill_off,
   output logic [ADDR_W-1:0]          fill_addr,
   output logic [$clog2(WAYS)-1:0]    fill_way,
   output logic                       update
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int CNT_W = OFF_W + 1;

   fill_state_t       state, state_nxt;
   logic [CNT_W-1:0]  issue_cnt, ret_cnt;
   logic [ADDR_W-1:0] base;
   logic [WAY_W-1:0]  way;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      mem_rd_req = 1'b0;
      fill_we    = 1'b0;
      update     = 1'b0;
      case (state)
         IDLE: if (miss) state_nxt = FILL;
         FILL: begin
            mem_rd_req = (issue_cnt != CNT_W'(WORDS));
            fill_we    = mem_rd_valid;
            // Leave on the edge that delivers the final word.
            if (mem_rd_valid && ret_cnt == CNT_W'(WORDS - 1)) state_nxt = UPDATE;
         end
         UPDATE: begin
            update    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
         ret_cnt   <= '0;
         base      <= '0;
         way       <= '0;
      end else if (state == IDLE) begin
         if (miss) begin
            base <= req_addr & ~ADDR_W'(2 * WORDS - 1);
            way  <= victim;
         end
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else if (state == FILL) begin
         if (mem_rd_req)   issue_cnt <= issue_cnt + CNT_W'(1);
         if (mem_rd_valid) ret_cnt   <= ret_cnt + CNT_W'(1);
      end
   end

   assign idle        = (state == IDLE);
   assign start       = idle & miss;
   assign stall       = miss | ~idle;
   assign mem_rd_addr = mem_rd_req ? (base | (ADDR_W'(issue_cnt) << 1)) : '0;
   assign fill_off    = ret_cnt[OFF_W-1:0];
   assign fill_addr   = base;
   assign fill_way    = way;
endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative cache with true-LRU ages; tag/data arrays, hit and victim selection here,
// block refill sequencing in cache_fill_ctrl.
module assoc_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SETS   = DEF_SETS,
   parameter int WAYS   = DEF_WAYS,
   parameter int WORDS  = DEF_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_wen,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              hit,
   output logic              stall,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = tag_width(ADDR_W, SETS, WORDS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int AGE_W = $clog2(WAYS);

   logic [SETS-1:0]   valid_q [WAYS];
   logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
   logic [AGE_W-1:0]  age_q   [WAYS][SETS];
   logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              addr_lsb_unused;
   logic [WAYS-1:0]   way_hit;
   logic [WAY_W-1:0]  hit_way, victim;
   logic              idle, start, miss, update, fill_we;
   logic [OFF_W-1:0]  fill_off;
   logic [ADDR_W-1:0] fill_addr;
   logic [WAY_W-1:0]  fill_way;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic [OFF_W:0]    fill_lo_unused;
   logic              touch;
   logic [WAY_W-1:0]  t_way;
   logic [IDX_W-1:0]  t_idx;

   assign off             = req_addr[OFF_W:1];
   assign idx             = req_addr[OFF_W+IDX_W:OFF_W+1];
   assign tag             = req_addr[ADDR_W-1:OFF_W+IDX_W+1];
   assign addr_lsb_unused = req_addr[0];
   assign fill_idx        = fill_addr[OFF_W+IDX_W:OFF_W+1];
   assign fill_tag        = fill_addr[ADDR_W-1:OFF_W+IDX_W+1];
   assign fill_lo_unused  = fill_addr[OFF_W:0];

   always_comb begin
      way_hit = '0;
      hit_way = '0;
      rdata   = '0;
      for (int w = 0; w < WAYS; w++) begin
         way_hit[w] = req_valid && valid_q[w][idx] && (tag_q[w][idx] == tag);
         if (way_hit[w]) hit_way = WAY_W'(w);
      end
      if (idle && |way_hit) rdata = data_q[hit_way][idx][off];
   end

   // Requests are only honoured in IDLE; no bypass from a fill in progress.
   assign hit  = idle & (|way_hit);
   assign miss = req_valid & ~(|way_hit);

   always_comb begin
      victim = '0;
      for (int w = 0; w < WAYS; w++)
         if (age_q[w][idx] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[w][idx]) victim = WAY_W'(w);
   end

   cache_fill_ctrl #(.ADDR_W(ADDR_W), .WAYS(WAYS), .WORDS(WORDS)) u_fill (
      .clk          (clk),
      .rst          (rst),
      .miss         (miss),
      .req_addr     (req_addr),
      .victim       (victim),
      .mem_rd_valid (mem_rd_valid),
      .idle         (idle),
      .start        (start),
      .stall        (stall),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_addr  (mem_rd_addr),
      .fill_we      (fill_we),
      .fill_off     (fill_off),
      .fill_addr    (fill_addr),
      .fill_way     (fill_way),
      .update       (update)
   );

   assign touch = hit | update;
   assign t_way = update ? fill_way : hit_way;
   assign t_idx = update ? fill_idx : idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
               age_q[w][s] <= AGE_W'(w);
      end else if (touch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == t_way)
               age_q[w][t_idx] <= '0;
            else if (age_q[w][t_idx] < age_q[t_way][t_idx])
               age_q[w][t_idx] <= age_q[w][t_idx] + AGE_W'(1);
         end
      end
   end

   // The victim is invalidated as soon as its refill begins so stale words never hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end else if (start) begin
         valid_q[victim][idx] <= 1'b0;
      end else if (update) begin
         valid_q[fill_way][fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (update) tag_q[fill_way][fill_idx] <= fill_tag;
      if (fill_we) data_q[fill_way][fill_idx][fill_off] <= mem_rd_data;
      if (hit && req_wen) data_q[hit_way][idx][off] <= req_wdata;
   end
endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed vectors, reset-during-fill, 4-way eviction and a randomized
// run against a recency-list reference model, all fed by a latency-4 pipelined memory.
module tb_assoc_cache;
   localparam int L        = 4;
   localparam int MISS_LAT = 8 + L + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv2, rv4, req_wen;
   logic [15:0] req_addr, req_wdata;
   logic [15:0] rdata2, rdata4, maddr2, maddr4, maddr, mem_rd_data;
   logic        hit2, hit4, stall2, stall4, mreq2, mreq4, mreq;
   logic        mem_v, stray_v, mem_rd_valid, sel4;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int q_addr[$];
   int q_cyc[$];
   int recent[$];
   logic [15:0] cdata [int];

   always #5 clk = ~clk;

   assign mem_rd_valid = mem_v | stray_v;
   assign mreq  = sel4 ? mreq4 : mreq2;
   assign maddr = sel4 ? maddr4 : maddr2;

   assoc_cache dut (
      .clk(clk), .rst(rst), .req_valid(rv2), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .rdata(rdata2), .hit(hit2), .stall(stall2),
      .mem_rd_req(mreq2), .mem_rd_addr(maddr2), .mem_rd_data(mem_rd_data),
      .mem_rd_valid(mem_rd_valid)
   );

   assoc_cache #(.WAYS(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(rv4), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .rdata(rdata4), .hit(hit4), .stall(stall4),
      .mem_rd_req(mreq4), .mem_rd_addr(maddr4), .mem_rd_data(mem_rd_data),
      .mem_rd_valid(mem_rd_valid)
   );

   function automatic logic [15:0] memfn(int a);
      return 16'h1000 + 16'(a >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Pipelined memory: each issue returns exactly L cycles later, in order.
   initial begin
      mem_v = 1'b0;
      mem_rd_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q_addr.delete();
            q_cyc.delete();
         end else if (mreq) begin
            q_addr.push_back(int'(maddr));
            q_cyc.push_back(cyc);
         end
         @(posedge clk);
         #1;
         cyc++;
         mem_v = 1'b0;
         if (q_cyc.size() > 0 && q_cyc[0] + L == cyc) begin
            mem_v = 1'b1;
            mem_rd_data = memfn(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_cyc.pop_front());
         end
      end
   end

   // Reference: per-set true LRU expressed as one global most-recent-first list of block numbers.
   task automatic model_access(input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                               input int ways, output logic exp_hit, output logic [15:0] exp_rd);
      int wa   = int'(addr) >> 1;
      int line = wa / 8;
      int set  = line % 64;
      int n    = 0;
      int pos  = -1;
      foreach (recent[i]) if (recent[i] == line) pos = i;
      exp_hit = (pos >= 0);
      if (pos >= 0) begin
         recent.delete(pos);
      end else begin
         foreach (recent[i]) if (recent[i] % 64 == set) n++;
         if (n == ways) begin
            for (int i = recent.size() - 1; i >= 0; i--) begin
               if (recent[i] % 64 == set) begin
                  for (int k = 0; k < 8; k++) cdata.delete(recent[i] * 8 + k);
                  recent.delete(i);
                  break;
               end
            end
         end
         for (int k = 0; k < 8; k++) cdata[line * 8 + k] = memfn((line * 8 + k) * 2);
      end
      recent.push_front(line);
      if (wen) cdata[wa] = wdata;
      exp_rd = cdata[wa];
   endtask

   // Called just after a rising edge; returns latency in cycles (-1 if no hit within budget).
   task automatic access(input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic use4, output int lat, output logic [15:0] rd);
      lat = -1;
      rd  = '0;
      req_wen = wen;
      req_addr = addr;
      req_wdata = wdata;
      if (use4) rv4 = 1'b1;
      else      rv2 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (use4 ? hit4 : hit2) begin
            lat = c;
            rd  = use4 ? rdata4 : rdata2;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (lat >= 0) begin
         @(posedge clk);
         #1;
      end
      rv2 = 1'b0;
      rv4 = 1'b0;
   endtask

   typedef struct {
      logic        wen;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] rdata;
   } vec_t;

   vec_t        tbl[13];
   int          lat;
   logic [15:0] rd;
   logic        w, eh;
   logic [15:0] a, d, er;

   initial begin
      tbl[0]  = '{1'b0, 16'h0006, 16'h0000, 0,        16'h1003};
      tbl[1]  = '{1'b1, 16'h0004, 16'hBEEF, 0,        16'h0000};
      tbl[2]  = '{1'b0, 16'h0004, 16'h0000, 0,        16'hBEEF};
      tbl[3]  = '{1'b0, 16'h0400, 16'h0000, MISS_LAT, 16'h1200};
      tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 0,        16'h1000};
      tbl[5]  = '{1'b0, 16'h0800, 16'h0000, MISS_LAT, 16'h1400};
      tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 0,        16'h1000};
      tbl[7]  = '{1'b0, 16'h0004, 16'h0000, 0,        16'hBEEF};
      tbl[8]  = '{1'b0, 16'h0400, 16'h0000, MISS_LAT, 16'h1200};
      tbl[9]  = '{1'b1, 16'h2010, 16'h1234, MISS_LAT, 16'h0000};
      tbl[10] = '{1'b0, 16'h2010, 16'h0000, 0,        16'h1234};
      tbl[11] = '{1'b0, 16'h2012, 16'h0000, 0,        16'h2009};
      tbl[12] = '{1'b0, 16'h0800, 16'h0000, MISS_LAT, 16'h1400};

      rst = 1'b1; rv2 = 1'b0; rv4 = 1'b0; req_wen = 1'b0;
      req_addr = '0; req_wdata = '0; stray_v = 1'b0; sel4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_rd_req", int'(mreq2), 0);
      check("rst_mem_rd_addr", int'(maddr2), 0);
      check("rst_hit", int'(hit2), 0);
      check("rst_stall", int'(stall2), 0);
      check("rst_stall_w4", int'(stall4), 0);
      check("rst_mem_rd_req_w4", int'(mreq4), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // First miss: exact issue sequence and hit cycle.
      rv2 = 1'b1; req_wen = 1'b0; req_addr = 16'h0000;
      #1;
      check("miss_c0_stall", int'(stall2), 1);
      check("miss_c0_hit", int'(hit2), 0);
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk);
         #2;
         check($sformatf("issue_c%0d_req", c), int'(mreq2), (c <= 8) ? 1 : 0);
         if (c <= 8) check($sformatf("issue_c%0d_addr", c), int'(maddr2), 2 * (c - 1));
      end
      lat = -1;
      for (int c = 10; c < 40; c++) begin
         @(posedge clk);
         #2;
         if (hit2) begin
            lat = c;
            break;
         end
      end
      check("first_fill_lat", lat, MISS_LAT);
      check("first_fill_rdata", int'(rdata2), 16'h1000);
      @(posedge clk);
      #1;
      rv2 = 1'b0;

      foreach (tbl[i]) begin
         access(tbl[i].wen, tbl[i].addr, tbl[i].wdata, 1'b0, lat, rd);
         check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         if (!tbl[i].wen) check($sformatf("vec%0d_rdata", i), int'(rd), int'(tbl[i].rdata));
      end

      // Reset in the middle of a fill.
      rv2 = 1'b1; req_wen = 1'b0; req_addr = 16'h3000;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_fill_mem_rd_req", int'(mreq2), 0);
      rv2 = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      stray_v = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("stray_mem_rd_req", int'(mreq2), 0);
      check("stray_stall", int'(stall2), 0);
      stray_v = 1'b0;
      access(1'b0, 16'h3000, 16'h0, 1'b0, lat, rd);
      check("refill_lat", lat, MISS_LAT);
      check("refill_rdata", int'(rd), 16'h2800);
      access(1'b0, 16'h0000, 16'h0, 1'b0, lat, rd);
      check("post_rst_cold_lat", lat, MISS_LAT);

      // Randomized traffic against the reference model.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      recent.delete();
      cdata.delete();
      for (int i = 0; i < 120; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 7) << 1));
         d = 16'($urandom);
         model_access(w, a, d, 2, eh, er);
         access(w, a, d, 1'b0, lat, rd);
         check($sformatf("rnd%0d_lat@%h", i, a), lat, eh ? 0 : MISS_LAT);
         if (!w) check($sformatf("rnd%0d_rdata@%h", i, a), int'(rd), int'(er));
      end

      // Four-way: five tags into set 0, the first one filled is the one evicted.
      rst = 1'b1;
      sel4 = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int t = 0; t < 5; t++) begin
         access(1'b0, 16'(t * 16'h0400), 16'h0, 1'b1, lat, rd);
         check($sformatf("w4_fill%0d_lat", t), lat, MISS_LAT);
      end
      for (int t = 1; t < 5; t++) begin
         access(1'b0, 16'(t * 16'h0400), 16'h0, 1'b1, lat, rd);
         check($sformatf("w4_keep%0d_lat", t), lat, 0);
         check($sformatf("w4_keep%0d_rdata", t), int'(rd), int'(memfn(t * 16'h0400)));
      end
      access(1'b0, 16'h0000, 16'h0, 1'b1, lat, rd);
      check("w4_evicted_lat", lat, MISS_LAT);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
